// File: rtl/windowed_core.sv
// rtl/windowed_core.sv - multicycle fetch/decode/execute core with a windowed register file
// Instructions and data share one req/ack RAM port; one instruction is in flight at a time.
module windowed_core #(
  parameter int ADDR_W       = 32,
  parameter int REG_COUNT    = 128,
  parameter int GLOBAL_COUNT = 16,
  parameter int WIN_STEP     = 8,
  parameter int RESET_RPOS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic              halted,
  output logic              illegal,
  output logic              win_ovf,
  output logic [ADDR_W-1:0] ipointer,
  output logic [7:0]        opcode,
  output logic [7:0]        rpos,
  output logic [31:0]       instr_count,
  output logic [31:0]       running_total,
  input  logic [7:0]        dbg_sel,
  output logic [31:0]       dbg_val
);
  localparam int WIN = REG_COUNT - GLOBAL_COUNT;
  localparam int IW  = $clog2(REG_COUNT);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MOVI  = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_LD    = 8'h04;
  localparam logic [7:0] OP_ST    = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;
  localparam logic [7:0] OP_JZ    = 8'h07;
  localparam logic [7:0] OP_WINUP = 8'h08;
  localparam logic [7:0] OP_WINDN = 8'h09;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [ADDR_W-1:0] STEP4 = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] STEP8 = ADDR_W'(8);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_IMM, S_MEM, S_EXEC, S_RETIRE, S_HALT
  } state_t;

  state_t        state;
  logic [31:0]   ir;
  logic [31:0]   a_val, b_val, c_val;
  logic [IW-1:0] a_idx;
  logic          halting;
  logic [31:0]   rf [REG_COUNT];

  logic [7:0] dec_op, fa, fb, fc;
  assign dec_op = ir[7:0];
  assign fa     = ir[15:8];
  assign fb     = ir[23:16];
  assign fc     = ir[31:24];

  // Fields >= 64 address globals directly; lower fields are offsets into the rotating window.
  function automatic logic [IW-1:0] map_field(input logic [7:0] f, input logic [7:0] base);
    int idx;
    if (f >= 8'd64) idx = int'(f) - 64;
    else            idx = GLOBAL_COUNT + ((int'(base) + int'(f)) % WIN);
    return IW'(idx);
  endfunction

  function automatic logic bad_global(input logic [7:0] f);
    return (f >= 8'd64) && ((int'(f) - 64) >= GLOBAL_COUNT);
  endfunction

  logic [IW-1:0] ia, ib, ic;
  logic          known, use_a, use_b, use_c, dec_bad;

  always_comb begin
    ia    = map_field(fa, rpos);
    ib    = map_field(fb, rpos);
    ic    = map_field(fc, rpos);
    known = 1'b1;
    use_a = 1'b0;
    use_b = 1'b0;
    use_c = 1'b0;
    case (dec_op)
      OP_NOP, OP_WINUP, OP_WINDN, OP_HALT: ;
      OP_MOVI, OP_JMP: use_a = 1'b1;
      OP_ADD, OP_SUB: begin
        use_a = 1'b1;
        use_b = 1'b1;
        use_c = 1'b1;
      end
      OP_LD, OP_ST, OP_JZ: begin
        use_a = 1'b1;
        use_b = 1'b1;
      end
      default: known = 1'b0;
    endcase
    dec_bad = !known || (use_a && bad_global(fa)) || (use_b && bad_global(fb))
              || (use_c && bad_global(fc));
  end

  logic [7:0] rpos_up, rpos_dn;
  logic       up_wrap, dn_wrap;

  always_comb begin
    up_wrap = (int'(rpos) + WIN_STEP) >= WIN;
    rpos_up = up_wrap ? 8'(int'(rpos) + WIN_STEP - WIN) : 8'(int'(rpos) + WIN_STEP);
    dn_wrap = int'(rpos) < WIN_STEP;
    rpos_dn = dn_wrap ? 8'(int'(rpos) + WIN - WIN_STEP) : 8'(int'(rpos) - WIN_STEP);
  end

  logic        acked;
  logic        rf_we;
  logic [31:0] rf_wdata;
  assign acked = ram_req & ram_ack;

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = ram_rdata;
    case (state)
      S_EXEC: begin
        if (dec_op == OP_ADD) begin
          rf_we    = 1'b1;
          rf_wdata = b_val + c_val;
        end else if (dec_op == OP_SUB) begin
          rf_we    = 1'b1;
          rf_wdata = b_val - c_val;
        end
      end
      S_IMM:   rf_we = acked;
      S_MEM:   rf_we = acked && (dec_op == OP_LD);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[a_idx] <= rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_FETCH;
      ram_req       <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
      win_ovf       <= 1'b0;
      ipointer      <= '0;
      opcode        <= '0;
      rpos          <= 8'(RESET_RPOS);
      instr_count   <= '0;
      running_total <= '0;
      dbg_val       <= '0;
      ir            <= '0;
      a_val         <= '0;
      b_val         <= '0;
      c_val         <= '0;
      a_idx         <= '0;
      halting       <= 1'b0;
    end else begin
      dbg_val <= (int'(dbg_sel) < REG_COUNT) ? rf[dbg_sel[IW-1:0]] : '0;
      case (state)
        // Each request state raises req on entry unless the previous state already did.
        S_FETCH: begin
          if (!ram_req) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= ipointer;
          end else if (ram_ack) begin
            ram_req       <= 1'b0;
            ir            <= ram_rdata;
            running_total <= running_total + ram_rdata;
            state         <= S_DECODE;
          end
        end
        S_DECODE: begin
          opcode <= dec_op;
          a_idx  <= ia;
          a_val  <= rf[ia];
          b_val  <= rf[ib];
          c_val  <= rf[ic];
          if (dec_bad) begin
            illegal <= 1'b1;
            halted  <= 1'b1;
            state   <= S_HALT;
          end else if (dec_op == OP_MOVI) begin
            state <= S_IMM;
          end else if (dec_op == OP_LD || dec_op == OP_ST) begin
            state <= S_MEM;
          end else begin
            state <= S_EXEC;
          end
        end
        S_IMM: begin
          if (!ram_req) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= ipointer + STEP4;
          end else if (ram_ack) begin
            ram_req  <= 1'b0;
            ipointer <= ipointer + STEP8;
            state    <= S_RETIRE;
          end
        end
        S_MEM: begin
          if (!ram_req) begin
            ram_req   <= 1'b1;
            ram_we    <= (dec_op == OP_ST);
            ram_addr  <= ADDR_W'(b_val);
            ram_wdata <= a_val;
          end else if (ram_ack) begin
            ram_req  <= 1'b0;
            ram_we   <= 1'b0;
            ipointer <= ipointer + STEP4;
            state    <= S_RETIRE;
          end
        end
        S_EXEC: begin
          case (dec_op)
            OP_JMP: ipointer <= ADDR_W'(a_val);
            OP_JZ:  ipointer <= (b_val == 32'd0) ? ADDR_W'(a_val) : ipointer + STEP4;
            OP_WINUP: begin
              rpos     <= rpos_up;
              win_ovf  <= win_ovf | up_wrap;
              ipointer <= ipointer + STEP4;
            end
            OP_WINDN: begin
              rpos     <= rpos_dn;
              win_ovf  <= win_ovf | dn_wrap;
              ipointer <= ipointer + STEP4;
            end
            OP_HALT: halting <= 1'b1;
            default: ipointer <= ipointer + STEP4;
          endcase
          state <= S_RETIRE;
        end
        S_RETIRE: begin
          instr_count <= instr_count + 32'd1;
          if (halting) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= ipointer;
            state    <= S_FETCH;
          end
        end
        S_HALT:  ram_req <= 1'b0;
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_windowed_core.sv
// tb/tb_windowed_core.sv - scoreboard bench for windowed_core
module tb_windowed_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_b, reset_s, use_small;
  logic [7:0] dbg_sel;

  logic b_req, b_we, b_halted, b_illegal, b_ovf;
  logic [31:0] b_addr, b_wdata, b_ip, b_cnt, b_total, b_dbg;
  logic [7:0] b_op, b_rpos;
  logic s_req, s_we, s_halted, s_illegal, s_ovf;
  logic [31:0] s_addr, s_wdata, s_ip, s_cnt, s_total, s_dbg;
  logic [7:0] s_op, s_rpos;

  logic [31:0] mem [0:1023];
  logic        m_req, m_we, halted_m, rst_m, ack, b_ack, s_ack;
  logic [31:0] m_addr, m_wdata, rdata;
  logic        hold_ack = 1'b0, force_ack = 1'b0;
  int          max_delay = 0, cnt = 0, delay = 0;
  logic        ld_en = 1'b0;
  int          ld_idx = 0;
  logic [31:0] ld_data = '0;

  assign m_req    = use_small ? s_req : b_req;
  assign m_we     = use_small ? s_we : b_we;
  assign m_addr   = use_small ? s_addr : b_addr;
  assign m_wdata  = use_small ? s_wdata : b_wdata;
  assign halted_m = use_small ? s_halted : b_halted;
  assign rst_m    = use_small ? reset_s : reset_b;
  assign ack      = force_ack | (m_req & ~hold_ack & (cnt >= delay));
  assign b_ack    = use_small ? 1'b0 : ack;
  assign s_ack    = use_small ? ack : 1'b0;
  assign rdata    = mem[m_addr[11:2]];

  windowed_core dut_b (
    .clk(clk), .reset(reset_b), .ram_req(b_req), .ram_we(b_we), .ram_addr(b_addr),
    .ram_wdata(b_wdata), .ram_rdata(rdata), .ram_ack(b_ack), .halted(b_halted),
    .illegal(b_illegal), .win_ovf(b_ovf), .ipointer(b_ip), .opcode(b_op), .rpos(b_rpos),
    .instr_count(b_cnt), .running_total(b_total), .dbg_sel(dbg_sel), .dbg_val(b_dbg)
  );

  windowed_core #(.REG_COUNT(32), .GLOBAL_COUNT(16), .WIN_STEP(8), .RESET_RPOS(2)) dut_s (
    .clk(clk), .reset(reset_s), .ram_req(s_req), .ram_we(s_we), .ram_addr(s_addr),
    .ram_wdata(s_wdata), .ram_rdata(rdata), .ram_ack(s_ack), .halted(s_halted),
    .illegal(s_illegal), .win_ovf(s_ovf), .ipointer(s_ip), .opcode(s_op), .rpos(s_rpos),
    .instr_count(s_cnt), .running_total(s_total), .dbg_sel(dbg_sel), .dbg_val(s_dbg)
  );

  // RAM model: combinational ack after a random number of wait cycles.
  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    if (m_req && ack) begin
      cnt   <= 0;
      delay <= int'($urandom_range(max_delay, 0));
      if (m_we) mem[m_addr[11:2]] <= m_wdata;
    end else if (m_req) begin
      cnt <= cnt + 1;
    end
  end

  int cyc = 0, drops = 0;
  logic pend = 1'b0;
  int ack_cyc [0:1023];
  int ack_hits [0:1023];
  logic [63:0] obs_w [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_m && m_req && ack) begin
      if (m_we) obs_w.push_back({m_addr, m_wdata});
      else begin
        ack_cyc[m_addr[11:2]]  <= cyc;
        ack_hits[m_addr[11:2]] <= ack_hits[m_addr[11:2]] + 1;
      end
    end
    if (rst_m && pend && !m_req) drops <= drops + 1;
    pend <= rst_m && m_req && !ack;
  end

  typedef struct {
    string       name;
    logic [7:0]  sel;
    logic [31:0] val;
  } exp_t;
  exp_t        exp_q [$];
  logic [63:0] wexp_q [$];

  int total = 0, bad = 0;

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {c, b, a, op};
  endfunction

  task automatic poke(input int addr, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_idx  = addr >> 2;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic start_big();
    use_small = 1'b0;
    reset_b   = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!halted_m && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!halted_m) begin
      bad++;
      $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted_m, n);
    end
  endtask

  task automatic check_regs();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      dbg_sel = e.sel;
      repeat (2) @(negedge clk);
      total++;
      if (b_dbg !== e.val) begin
        bad++;
        $display("FAIL reg_%s: dbg_val[%0d]=%h required %h", e.name, e.sel, b_dbg, e.val);
      end
    end
  endtask

  logic [31:0] prog1_sum;

  task automatic load_prog1();
    poke(32'h00, ins(8'h01, 8'd0, 8'd0, 8'd0));
    poke(32'h04, 32'd5);
    poke(32'h08, ins(8'h01, 8'd1, 8'd0, 8'd0));
    poke(32'h0C, 32'd7);
    poke(32'h10, ins(8'h02, 8'd2, 8'd0, 8'd1));
    poke(32'h14, ins(8'hFF, 8'd0, 8'd0, 8'd0));
    prog1_sum = ins(8'h01, 8'd0, 8'd0, 8'd0) + ins(8'h01, 8'd1, 8'd0, 8'd0)
              + ins(8'h02, 8'd2, 8'd0, 8'd1) + ins(8'hFF, 8'd0, 8'd0, 8'd0);
    exp_q.push_back('{name: "r2", sel: 8'd20, val: 32'd12});
    exp_q.push_back('{name: "r0", sel: 8'd18, val: 32'd5});
    exp_q.push_back('{name: "r1", sel: 8'd19, val: 32'd7});
  endtask

  task automatic check_prog1_state(input string tag);
    total++;
    if (b_cnt !== 32'd4) begin bad++; $display("FAIL %s_count: instr_count=%0d required 4", tag, b_cnt); end
    total++;
    if (b_ip !== 32'h14) begin bad++; $display("FAIL %s_ip: ipointer=%h required 14", tag, b_ip); end
    total++;
    if (b_illegal !== 1'b0) begin bad++; $display("FAIL %s_illegal: illegal=%0b required 0", tag, b_illegal); end
    total++;
    if (b_total !== prog1_sum) begin bad++; $display("FAIL %s_total: running_total=%h required %h", tag, b_total, prog1_sum); end
    check_regs();
  endtask

  task automatic test_reset();
    use_small = 1'b0;
    reset_b   = 1'b0;
    reset_s   = 1'b0;
    dbg_sel   = 8'd20;
    repeat (3) @(negedge clk);
    total++;
    if (b_req !== 1'b0) begin bad++; $display("FAIL reset_req: ram_req=%0b required 0", b_req); end
    total++;
    if (b_rpos !== 8'd2) begin bad++; $display("FAIL reset_rpos: rpos=%0d required 2", b_rpos); end
    total++;
    if (b_cnt !== 32'd0 || b_ip !== 32'd0 || b_total !== 32'd0) begin
      bad++;
      $display("FAIL reset_counters: count=%0d ip=%h total=%h required all 0", b_cnt, b_ip, b_total);
    end
    total++;
    if (b_halted !== 1'b0 || b_illegal !== 1'b0 || b_ovf !== 1'b0 || b_dbg !== 32'd0) begin
      bad++;
      $display("FAIL reset_flags: halted=%0b illegal=%0b ovf=%0b dbg=%h required 0", b_halted, b_illegal, b_ovf, b_dbg);
    end
  endtask

  task automatic test_zero_wait();
    max_delay = 0;
    load_prog1();
    start_big();
    run_to_halt(300);
    total++;
    if (ack_cyc[2] - ack_cyc[0] !== 5) begin bad++; $display("FAIL lat_movi: %0d cycles required 5", ack_cyc[2] - ack_cyc[0]); end
    total++;
    if (ack_cyc[5] - ack_cyc[4] !== 4) begin bad++; $display("FAIL lat_add: %0d cycles required 4", ack_cyc[5] - ack_cyc[4]); end
    check_prog1_state("zw");
  endtask

  task automatic test_random_wait();
    int d0;
    max_delay = 5;
    reset_b = 1'b0;
    load_prog1();
    d0 = drops;
    start_big();
    run_to_halt(1000);
    check_prog1_state("rw");
    total++;
    if (drops !== d0) begin bad++; $display("FAIL req_drop: early drops=%0d required 0", drops - d0); end
    max_delay = 0;
  endtask

  task automatic test_window();
    reset_b = 1'b0;
    poke(32'h00, ins(8'h01, 8'd64, 8'd0, 8'd0));
    poke(32'h04, 32'hAA);
    poke(32'h08, ins(8'h08, 8'd0, 8'd0, 8'd0));
    poke(32'h0C, ins(8'h02, 8'd0, 8'd64, 8'd64));
    poke(32'h10, ins(8'hFF, 8'd0, 8'd0, 8'd0));
    exp_q.push_back('{name: "global0", sel: 8'd0, val: 32'hAA});
    exp_q.push_back('{name: "win_r0", sel: 8'd26, val: 32'h154});
    start_big();
    run_to_halt(300);
    total++;
    if (b_rpos !== 8'd10) begin bad++; $display("FAIL win_rpos: rpos=%0d required 10", b_rpos); end
    total++;
    if (b_cnt !== 32'd4) begin bad++; $display("FAIL win_count: instr_count=%0d required 4", b_cnt); end
    check_regs();
  endtask

  task automatic test_jz_loop();
    int h30, h34;
    logic [63:0] got, want;
    reset_b = 1'b0;
    poke(32'h00, ins(8'h01, 8'd0, 8'd0, 8'd0)); poke(32'h04, 32'd3);
    poke(32'h08, ins(8'h01, 8'd1, 8'd0, 8'd0)); poke(32'h0C, 32'd1);
    poke(32'h10, ins(8'h01, 8'd4, 8'd0, 8'd0)); poke(32'h14, 32'h100);
    poke(32'h18, ins(8'h01, 8'd3, 8'd0, 8'd0)); poke(32'h1C, 32'h34);
    poke(32'h20, ins(8'h01, 8'd2, 8'd0, 8'd0)); poke(32'h24, 32'h28);
    poke(32'h28, ins(8'h03, 8'd0, 8'd0, 8'd1));
    poke(32'h2C, ins(8'h07, 8'd3, 8'd0, 8'd0));
    poke(32'h30, ins(8'h06, 8'd2, 8'd0, 8'd0));
    poke(32'h34, ins(8'h05, 8'd0, 8'd4, 8'd0));
    poke(32'h38, ins(8'hFF, 8'd0, 8'd0, 8'd0));
    poke(32'h100, 32'hDEADBEEF);
    wexp_q.push_back({32'h100, 32'd0});
    h30 = ack_hits[12];
    h34 = ack_hits[13];
    start_big();
    run_to_halt(2000);
    total++;
    if (obs_w.size() == 0 || wexp_q.size() == 0) begin
      bad++;
      $display("FAIL st_write: observed %0d writes, expected %0d", obs_w.size(), wexp_q.size());
    end else begin
      got  = obs_w.pop_front();
      want = wexp_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL st_write: addr/data=%h required %h", got, want); end
    end
    total++;
    if (mem[64] !== 32'd0) begin bad++; $display("FAIL ram_100: RAM[0x100]=%h required 0", mem[64]); end
    total++;
    if (ack_hits[13] - h34 !== 1) begin bad++; $display("FAIL jz_taken: taken %0d times required 1", ack_hits[13] - h34); end
    total++;
    if (ack_hits[12] - h30 !== 2) begin bad++; $display("FAIL jz_fallthrough: %0d required 2", ack_hits[12] - h30); end
    total++;
    if (b_cnt !== 32'd15 || b_ip !== 32'h38) begin
      bad++;
      $display("FAIL jz_final: count=%0d ip=%h required 15 and 38", b_cnt, b_ip);
    end
  endtask

  task automatic test_small_window();
    reset_b   = 1'b0;
    use_small = 1'b1;
    reset_s   = 1'b0;
    poke(32'h00, ins(8'h08, 8'd0, 8'd0, 8'd0));
    poke(32'h04, ins(8'h08, 8'd0, 8'd0, 8'd0));
    poke(32'h08, ins(8'h42, 8'd0, 8'd0, 8'd0));
    @(negedge clk);
    reset_s = 1'b1;
    run_to_halt(300);
    repeat (3) @(negedge clk);
    total++;
    if (s_rpos !== 8'd2 || s_ovf !== 1'b1) begin
      bad++;
      $display("FAIL small_wrap: rpos=%0d win_ovf=%0b required 2 and 1", s_rpos, s_ovf);
    end
    total++;
    if (s_illegal !== 1'b1 || s_halted !== 1'b1 || s_req !== 1'b0) begin
      bad++;
      $display("FAIL small_illegal: illegal=%0b halted=%0b req=%0b required 1 1 0", s_illegal, s_halted, s_req);
    end
    total++;
    if (s_cnt !== 32'd2 || s_ip !== 32'h8 || s_op !== 8'h42) begin
      bad++;
      $display("FAIL small_state: count=%0d ip=%h opcode=%h required 2 8 42", s_cnt, s_ip, s_op);
    end
    reset_s   = 1'b0;
    use_small = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset_b = 1'b0;
    load_prog1();
    start_big();
    while (b_cnt < 32'd2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    hold_ack = 1'b1;
    n = 0;
    while (!b_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (b_req !== 1'b1) begin bad++; $display("FAIL mid_setup: ram_req=%0b required 1", b_req); end
    @(posedge clk);
    #2 reset_b = 1'b0;
    #1;
    total++;
    if (b_req !== 1'b0) begin bad++; $display("FAIL mid_req_drop: ram_req=%0b required 0", b_req); end
    total++;
    if (b_cnt !== 32'd0 || b_total !== 32'd0 || b_ip !== 32'd0 || b_rpos !== 8'd2) begin
      bad++;
      $display("FAIL mid_clear: count=%0d total=%h ip=%h rpos=%0d required 0 0 0 2", b_cnt, b_total, b_ip, b_rpos);
    end
    @(negedge clk);
    force_ack = 1'b1;
    reset_b   = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b0;
    total++;
    if (b_req !== 1'b1 || b_addr !== 32'd0 || b_we !== 1'b0 || b_total !== 32'd0) begin
      bad++;
      $display("FAIL late_ack: req=%0b addr=%h we=%0b total=%h required 1 0 0 0", b_req, b_addr, b_we, b_total);
    end
    @(negedge clk);
    hold_ack = 1'b0;
    run_to_halt(300);
    check_prog1_state("mid");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_random_wait();
    test_window();
    test_jz_loop();
    test_small_window();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/windowed_core.md
Name: windowed_core

Overview:
- Parametrised multicycle fetch/decode/execute core with a windowed register file.
- Fetches 32-bit instructions over a req/ack RAM port, executes a small ALU/memory/branch ISA and retires one instruction at a time.
- Generalises the earlier fixed-timing ALU in three ways: variable RAM latency via ack, parametrised register file and window, and real execution and branching.
- Sits between the instruction/data RAM arbiter and the debug/top-level harness.

Parameters:
- ADDR_W, 32, RAM byte-address width; ip advances by 4.
- REG_COUNT, 128, physical registers, each 32 bits.
- GLOBAL_COUNT, 16, physical regs 0..GLOBAL_COUNT-1 reached by operand fields >= 64.
- WIN_STEP, 8, rpos change applied by WINUP/WINDN.
- RESET_RPOS, 2, rpos value after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- ram_req  out  1  RAM request, held until acked
- ram_we  out  1  1 = write, 0 = read; valid while ram_req
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data, valid in the ack cycle
- ram_ack  in  1  completes the current request
- halted  out  1  core stopped (HALT or illegal)
- illegal  out  1  sticky, set on undefined opcode or bad global index
- win_ovf  out  1  sticky, set when rpos wraps
- ipointer  out  ADDR_W  current instruction address
- opcode  out  8  last decoded opcode
- rpos  out  8  current window base
- instr_count  out  32  retired instructions
- running_total  out  32  mod-2^32 sum of all fetched instruction words
- dbg_sel  in  8  physical register index for debug read
- dbg_val  out  32  registered value of regfile[dbg_sel]; 0 if out of range

Behaviour:
- Reset (reset=0, asynchronous): all outputs and the register file go to 0, except rpos=RESET_RPOS. State=FETCH. ram_req drops immediately, mid-transaction included; a late ack after release is ignored.
- Instruction word: [7:0] opcode, [15:8] A, [23:16] B, [31:24] C.
- Operand map for field f:
  - f >= 64: global, physical index f-64. If f-64 >= GLOBAL_COUNT, the instruction is illegal.
  - f < 64: physical index GLOBAL_COUNT + ((rpos+f) mod (REG_COUNT-GLOBAL_COUNT)).
- RAM handshake:
  - The core asserts ram_req with addr/we/wdata stable and holds it until a cycle with ram_ack=1.
  - ram_req deasserts the cycle after ack.
  - ram_ack while ram_req=0 is ignored.
- States:
  - FETCH: req read at ipointer. On ack, latch the word, add it to running_total, go to DECODE.
  - DECODE: map operands, read B/C/A values, set opcode. Go to IMM if MOVI, MEM if LD/ST, otherwise EXEC.
  - IMM: read at ipointer+4. On ack, write the word to A; ip += 8; go to RETIRE.
  - MEM: LD reads addr=B and writes rdata to A on ack. ST writes A to addr=B. Both do ip += 4 and go to RETIRE.
  - EXEC: perform the op and update ip; go to RETIRE.
  - RETIRE: instr_count += 1; go to FETCH, or to HALT if halting.
  - HALT: ram_req=0; only reset exits.
- Opcodes:
  - 00 NOP
  - 01 MOVI A <- next word
  - 02 ADD A <- B+C
  - 03 SUB A <- B-C
  - 04 LD A <- mem[B]
  - 05 ST mem[B] <- A
  - 06 JMP ip <- A
  - 07 JZ: if B==0 then ip <- A, else ip += 4
  - 08 WINUP rpos += WIN_STEP
  - 09 WINDN rpos -= WIN_STEP
  - FF HALT
  - Anything else: set illegal, halted=1, do not retire, ip unchanged.
- Arithmetic: 32-bit wrap, no flags.
- Window: rpos is kept mod (REG_COUNT-GLOBAL_COUNT). Any wrap sets win_ovf and execution continues.
- Latency with ack in the first req cycle:
  - reg-reg op: 4 cycles (FETCH, DECODE, EXEC, RETIRE)
  - MOVI/LD/ST: 5 cycles
  - each extra wait cycle adds 1.
- HALT retires: instr_count counts it and ip is not advanced.
- Register writes happen at the end of EXEC/IMM/MEM and are visible to the next instruction. When A aliases B or C, the read-before-write values are used.
- dbg_val updates every cycle, including while halted.

Test Plan:
- Zero-wait RAM: MOVI r0,5; MOVI r1,7; ADD r2,r0,r1; HALT -> r2 (phys 16+2+2=20) = 12, instr_count=4, halted=1, ipointer=0x14.
- Random 0..5-cycle ack delay on the same program -> identical final state; ram_req never drops before ack.
- Global/window: MOVI g(f=64),0xAA; WINUP; ADD r0,g,g -> phys 16+10=26 holds 0x154, global 0 holds 0xAA.
- JZ loop counting r0 from 3 to 0 with SUB, then ST to 0x100 -> RAM[0x100]=0, JZ is taken exactly once.
- REG_COUNT=32, GLOBAL_COUNT=16, WIN_STEP=8, RESET_RPOS=2: WINUP twice -> rpos=2, win_ovf=1. Opcode 0x42 -> illegal=1, halted=1, instr_count unchanged.
- Reset asserted mid-FETCH with ram_req=1 -> ram_req=0 in the same cycle, all counters 0. After release, the first access is a fetch at address 0.
